// File: rtl/row_scan_sequencer.sv
// Row-scan address sequencer: steps W..Z through 0..limit (or limit..0), holding each address DIV cycles.
// All outputs registered; stop aborts immediately, start is only honoured in IDLE.
module row_scan_sequencer #(
  parameter int DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode_cont,
  input  logic       dir_down,
  input  logic [3:0] limit,
  output logic       W,
  output logic       X,
  output logic       Y,
  output logic       Z,
  output logic       valid,
  output logic       busy,
  output logic       done,
  output logic       wrap
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_DONE} state_t;

  localparam logic [15:0] PRE_LAST = 16'(DIV - 1);

  state_t      state, state_nxt;
  logic [3:0]  addr, addr_nxt;
  logic [15:0] pre, pre_nxt;
  logic [3:0]  lim, lim_nxt;
  logic        cont, cont_nxt;
  logic        down, down_nxt;
  logic        valid_nxt, busy_nxt, done_nxt, wrap_nxt;
  logic        tick, at_end, accept;

  assign tick   = (pre == PRE_LAST);
  assign at_end = down ? (addr == 4'd0) : (addr == lim);
  assign accept = start && !stop;

  assign {W, X, Y, Z} = addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      addr  <= 4'd0;
      pre   <= 16'd0;
      lim   <= 4'd0;
      cont  <= 1'b0;
      down  <= 1'b0;
      valid <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      state <= state_nxt;
      addr  <= addr_nxt;
      pre   <= pre_nxt;
      lim   <= lim_nxt;
      cont  <= cont_nxt;
      down  <= down_nxt;
      valid <= valid_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
      wrap  <= wrap_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (stop)                        state_nxt = ST_IDLE;
        else if (tick && at_end && !cont) state_nxt = ST_DONE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Computes the next registered output values so every output comes straight from a flop.
  always_comb begin
    addr_nxt  = addr;
    pre_nxt   = pre;
    lim_nxt   = lim;
    cont_nxt  = cont;
    down_nxt  = down;
    valid_nxt = 1'b0;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    case (state)
      ST_IDLE: begin
        addr_nxt = 4'd0;
        pre_nxt  = 16'd0;
        if (accept) begin
          lim_nxt   = limit;
          cont_nxt  = mode_cont;
          down_nxt  = dir_down;
          addr_nxt  = dir_down ? limit : 4'd0;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end
      end
      ST_SCAN: begin
        if (stop) begin
          addr_nxt = 4'd0;
          pre_nxt  = 16'd0;
        end else if (!tick) begin
          pre_nxt   = pre + 16'd1;
          valid_nxt = 1'b1;
          busy_nxt  = 1'b1;
        end else begin
          pre_nxt = 16'd0;
          if (!at_end) begin
            addr_nxt  = down ? addr - 4'd1 : addr + 4'd1;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b1;
          end else if (cont) begin
            addr_nxt  = down ? lim : 4'd0;
            wrap_nxt  = 1'b1;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b1;
          end else begin
            done_nxt = 1'b1;
          end
        end
      end
      default: begin
        addr_nxt = 4'd0;
        pre_nxt  = 16'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_row_scan_sequencer.sv
// Scoreboard bench: three sequencers (DIV=1,2,4) driven per lane; a cycle-indexed reference trace is queued per lane.
module tb_row_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_i [3];
  logic       stop_i  [3];
  logic       mode_i  [3];
  logic       dir_i   [3];
  logic [3:0] limit_i [3];
  logic       w_o [3], x_o [3], y_o [3], z_o [3];
  logic       valid_o [3], busy_o [3], done_o [3], wrap_o [3];

  logic [7:0] q0 [$];
  logic [7:0] q1 [$];
  logic [7:0] q2 [$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    row_scan_sequencer #(.DIV(g == 0 ? 1 : (g == 1 ? 2 : 4))) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_i[g]), .stop(stop_i[g]),
      .mode_cont(mode_i[g]), .dir_down(dir_i[g]), .limit(limit_i[g]),
      .W(w_o[g]), .X(x_o[g]), .Y(y_o[g]), .Z(z_o[g]),
      .valid(valid_o[g]), .busy(busy_o[g]), .done(done_o[g]), .wrap(wrap_o[g])
    );
  end

  function automatic int lane_div(input int ln);
    return (ln == 0) ? 1 : ((ln == 1) ? 2 : 4);
  endfunction

  function automatic logic [7:0] obs(input int ln);
    return {w_o[ln], x_o[ln], y_o[ln], z_o[ln], valid_o[ln], busy_o[ln], done_o[ln], wrap_o[ln]};
  endfunction

  // Expected {addr, valid, busy, done, wrap} k cycles after the start was accepted.
  function automatic logic [7:0] exp_at(input int div, input int lim, input bit down,
                                        input bit cont, input int stop_at, input int k);
    int slot, s;
    logic [3:0] a;
    if (stop_at >= 0 && k >= stop_at) return 8'h00;
    slot = k / div;
    if (!cont) begin
      if (slot <= lim) begin
        a = 4'(down ? lim - slot : slot);
        return {a, 4'b1100};
      end
      if (k == (lim + 1) * div) begin
        a = 4'(down ? 0 : lim);
        return {a, 4'b0010};
      end
      return 8'h00;
    end
    s = slot % (lim + 1);
    a = 4'(down ? lim - s : s);
    return {a, 3'b110, (slot > 0 && s == 0 && (k % div) == 0)};
  endfunction

  function automatic void push(input int ln, input logic [7:0] e);
    if (ln == 0) q0.push_back(e);
    else if (ln == 1) q1.push_back(e);
    else q2.push_back(e);
  endfunction

  function automatic void compare(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got addr=%0d v/b/d/w=%b required addr=%0d v/b/d/w=%b",
               name, $time, act[7:4], act[3:0], req[7:4], req[3:0]);
    end
  endfunction

  // Monitor: every lane is checked every cycle; an empty queue means the lane must be idle.
  always @(negedge clk) begin
    logic [7:0] e;
    e = (q0.size() > 0) ? q0.pop_front() : 8'h00;
    compare("lane0_div1", obs(0), e);
    e = (q1.size() > 0) ? q1.pop_front() : 8'h00;
    compare("lane1_div2", obs(1), e);
    e = (q2.size() > 0) ? q2.pop_front() : 8'h00;
    compare("lane2_div4", obs(2), e);
  end

  task automatic idle(input int ln, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk); #1;
      start_i[ln] = 1'b0;
      stop_i[ln]  = 1'b0;
      push(ln, 8'h00);
    end
  endtask

  // One sweep request; step k drives inputs sampled at the edge that opens cycle k.
  task automatic run(input int ln, input int lim, input bit down, input bit cont,
                     input int ncyc, input int stop_at, input bit noise);
    int div;
    bit prev_active;
    div = lane_div(ln);
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk); #1;
      if (k == 0) begin
        start_i[ln] = 1'b1;
        stop_i[ln]  = 1'b0;
        limit_i[ln] = 4'(lim);
        mode_i[ln]  = cont;
        dir_i[ln]   = down;
      end else begin
        prev_active = (stop_at < 0 || k - 1 < stop_at) && (cont || k - 1 <= (lim + 1) * div);
        start_i[ln] = noise && prev_active && ($urandom_range(0, 1) == 1);
        stop_i[ln]  = (k == stop_at);
        if (noise) begin
          limit_i[ln] = 4'($urandom_range(0, 15));
          mode_i[ln]  = 1'($urandom_range(0, 1));
          dir_i[ln]   = 1'($urandom_range(0, 1));
        end
      end
      push(ln, exp_at(div, lim, down, cont, stop_at, k));
    end
  endtask

  initial begin
    int ln, lim, div, stop_at, ncyc;
    bit down, cont, noise;
    for (int i = 0; i < 3; i++) begin
      start_i[i] = 1'b0; stop_i[i] = 1'b0; mode_i[i] = 1'b0;
      dir_i[i] = 1'b0; limit_i[i] = 4'd0;
    end
    repeat (2) @(negedge clk);
    compare("reset_state", obs(2), 8'h00);
    #2 rst_n = 1'b1;

    // DIV=4, limit 3, up, single; then a restart in the first IDLE cycle after done.
    run(2, 3, 1'b0, 1'b0, 18, -1, 1'b0);
    run(2, 3, 1'b0, 1'b0, 18, -1, 1'b0);
    idle(2, 2);
    // DIV=2, limit 5, down, single, with limit/mode/dir and start scrambled mid-sweep.
    run(1, 5, 1'b1, 1'b0, 14, -1, 1'b1);
    idle(1, 2);
    // DIV=1, limit 2, continuous up, then stop.
    run(0, 2, 1'b0, 1'b1, 12, 10, 1'b0);
    idle(0, 1);
    // Full range without rollover, then the single-slot limit=0 sweep.
    run(0, 15, 1'b0, 1'b0, 18, -1, 1'b0);
    run(0, 0, 1'b0, 1'b0, 3, -1, 1'b0);
    run(0, 15, 1'b1, 1'b0, 18, -1, 1'b0);
    // start together with stop in IDLE is refused.
    @(negedge clk); #1;
    start_i[1] = 1'b1; stop_i[1] = 1'b1; limit_i[1] = 4'd4;
    push(1, 8'h00);
    idle(1, 3);

    for (int r = 0; r < 30; r++) begin
      ln    = $urandom_range(0, 2);
      div   = lane_div(ln);
      lim   = $urandom_range(0, 15);
      down  = 1'($urandom_range(0, 1));
      cont  = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      if (cont) begin
        stop_at = $urandom_range(1, 3 * (lim + 1) * div);
        ncyc    = stop_at + 2;
      end else begin
        stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(1, (lim + 1) * div) : -1;
        ncyc    = (lim + 1) * div + 2;
      end
      run(ln, lim, down, cont, ncyc, stop_at, noise);
      idle(ln, 2);
    end

    // Asynchronous reset while lane 1 shows address 7.
    run(1, 15, 1'b0, 1'b0, 15, -1, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1 compare("async_reset", obs(1), 8'h00);
    @(negedge clk); #2;
    rst_n = 1'b1;
    run(1, 3, 1'b0, 1'b0, 10, -1, 1'b0);
    idle(1, 2);

    repeat (3) @(negedge clk);
    #1 compare("scoreboard_drained", 8'(q0.size() + q1.size() + q2.size()), 8'h00);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/row_scan_sequencer.md
# row_scan_sequencer

Registered 4-bit address sequencer that drives the select inputs (W, X, Y, Z) of the 4-to-16 decoder stage, stepping one output line at a time for LED/keypad row scanning. Each address is held for a fixed number of clock cycles, and sweeps run up or down to a programmable limit, either once or continuously. Start/stop control, a valid qualifier and one-cycle done/wrap pulses let a controller sequence it.

## Interface
- DIV, default 4: clock cycles each address is held (slot length); legal range 1..65535.
- clk  input  1  rising-edge clock, the only clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  level sampled each cycle; begins a sweep when in IDLE.
- stop  input  1  aborts the sweep; has priority over start and over slot advance.
- mode_cont  input  1  1 = continuous sweeps, 0 = single sweep; latched on start.
- dir_down  input  1  1 = count down from limit to 0, 0 = count up from 0 to limit; latched on start.
- limit  input  4  last (up) or first (down) address; latched on start.
- W  output  1  address bit 3 (MSB), to decoder W.
- X  output  1  address bit 2, to decoder X.
- Y  output  1  address bit 1, to decoder Y.
- Z  output  1  address bit 0 (LSB), to decoder Z.
- valid  output  1  address on W..Z is an active scan slot.
- busy  output  1  a sweep is in progress (state SCAN).
- done  output  1  one-cycle pulse: single sweep completed.
- wrap  output  1  one-cycle pulse: continuous sweep restarted.

## Operation
- States: IDLE, SCAN, DONE. All outputs are registered.
- Reset (async, rst_n=0): state IDLE; W,X,Y,Z = 0; valid, busy, done, wrap = 0; prescaler = 0; latched limit/mode/dir = 0.
- IDLE: addr = 0, valid = busy = 0. On start=1 and stop=0: latch limit, mode_cont, dir_down; addr = dir_down ? limit : 0; prescaler = 0; go to SCAN.
- SCAN: valid = busy = 1. The prescaler counts 0..DIV-1. Tick = (prescaler == DIV-1); on tick, prescaler returns to 0.
- On tick, if not the end address (up: addr==lim; down: addr==0): addr steps ±1.
- On tick at the end address with mode continuous: addr reloads the start value (0 or lim), wrap = 1 for one cycle, and the state stays SCAN.
- On tick at the end address with mode single: go to DONE.
- DONE (one cycle): done = 1, valid = busy = 0, addr holds the last value; then IDLE with addr = 0.
- stop=1 in SCAN or DONE: next state IDLE, addr = 0, no done pulse, prescaler cleared.
- stop=1 with start=1 in IDLE: remain IDLE.
- start during SCAN/DONE: ignored. Changes to limit/mode_cont/dir_down after start: ignored until the next start.
- limit=0: each sweep is a single slot at address 0.
- Address arithmetic is 4-bit, never wraps through 15→0 or 0→15; the end-address check always fires first.

## Timing
- start sampled at edge n → valid=1 and first address on W..Z from edge n (visible cycle n+1).
- Every slot lasts exactly DIV cycles, including the first and last slot, and the first slot after a wrap.
- Single sweep, limit L: valid high for (L+1)·DIV cycles; done high for the single cycle immediately following.
- Earliest restart: start may be accepted in the cycle after done (first IDLE cycle).
- wrap rises in the same cycle the reloaded start address appears; it is never asserted together with done.
- stop sampled at edge m → valid=0, W..Z=0 from edge m.
- DIV=1: the address changes every cycle.
- Reset mid-sweep: outputs go to reset values immediately, without waiting for clk.

## Test plan
- DIV=4, limit=3, up, single, start pulse → W..Z = 0,1,2,3 each held 4 cycles; valid 16 cycles; done 1 cycle; then addr 0, busy 0.
- DIV=2, limit=5, dir_down=1, single → addresses 5,4,3,2,1,0 each held 2 cycles, then done; limit changed to 9 mid-sweep has no effect.
- DIV=1, limit=2, continuous, up → 0,1,2,0,1,2…; wrap high exactly in the cycles showing the restarted 0; done never asserted; stop → addr 0, valid 0 next edge.
- limit=15, DIV=1, up, single → 0..15 each for one cycle, no rollover, done after the 15 slot; limit=0 → one slot at 0, then done.
- start and stop both high in IDLE → stays IDLE. start high again during SCAN → sequence unchanged.
- rst_n low mid-sweep (addr=7) → all outputs 0 asynchronously; after release, start gives a clean sweep from 0.
